ff_frame_packer: RTL and testbench
==================================

// Module: ff_frame_packer
// PURPOSE
//  Parametrised successor to the ff_clk-side frame assembler. Packs the demodulator's serial stream
//  (IN_W bits per ff_en beat) into frames of {payload, frame ID} and holds them in an NBUF-deep ring of
//  frame buffers. Hands completed frames to the MAC transmit side with a valid/ack handshake. Drops
//  whole frames, and counts them, when every buffer is occupied.
// PARAMETERS
//  IN_W          1     data bits accepted per ff_en beat (1,2,4,8)
//  PAYLOAD_BITS  625   payload bits per frame; must be a multiple of IN_W
//  ID_W          24    frame-ID field width
//  NBUF          2     frame buffers in the ring (>=2)
//  FRAME_W       ID_W+PAYLOAD_BITS (localparam); BEATS=PAYLOAD_BITS/IN_W (localparam)
// PORTS
//  ff_clk       in   1                 stream clock
//  reset        in   1                 synchronous, active-high
//  ff_en        in   1                 beat strobe: ff_data is valid
//  ff_data      in   IN_W              stream data; bit 0 is the earliest bit in time
//  start        in   1                 stream enable; a low level aborts any partial frame
//  frame_valid  out  1                 head buffer holds a complete frame
//  frame_data   out  FRAME_W           head frame: [ID_W-1:0]=ID, [ID_W+k]=k-th payload bit received
//  frame_ack    in   1                 consumer pops the head frame (honoured only when frame_valid=1)
//  level        out  $clog2(NBUF+1)    number of complete frames held
//  busy         out  1                 a frame is being filled or dropped
//  overflow     out  1                 one-cycle pulse when a frame drop begins
//  drop_cnt     out  16                dropped-frame count; saturates at 16'hFFFF
//  frameid      in   ID_W              external ID (used only with FF_PACK_EXT_ID_EN)
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=rd_ptr=0, level=0, frame_valid=0, busy=0, overflow=0, drop_cnt=0,
//   internal ID counter=0. Buffer contents are don't-care. frame_data is don't-care while frame_valid=0.
//  Beat = ff_clk edge with ff_en&start. All other edges do nothing, except the abort rule below.
//  FSM:
//   IDLE: on a beat with level<NBUF -> FILL. The beat is stored at payload[IN_W-1:0], the ID field
//    of buffer[wr_ptr] is latched, beat_cnt=1. On a beat with level==NBUF -> DROP, overflow=1 for one
//    cycle, beat_cnt=1.
//   FILL: each beat writes payload[beat_cnt*IN_W +: IN_W] and beat_cnt++. On the beat where
//    beat_cnt==BEATS-1: commit (wr_ptr wraps modulo NBUF, level++), ID+1, -> IDLE.
//   DROP: beats are discarded. On the last beat: drop_cnt++ (saturating), ID+1, -> IDLE.
//    IDs therefore show gaps downstream.
//   BEATS==1: the first beat also commits or drops in the same cycle.
//  Abort: start=0 while in FILL or DROP -> IDLE next edge. The partial frame is discarded, and no
//   commit, ID change or drop_cnt change occurs.
//  busy=1 in FILL or DROP.
//  Read: frame_valid=(level!=0). frame_data=buffer[rd_ptr], driven from registers with no extra
//   latency. frame_ack&frame_valid -> rd_ptr wraps modulo NBUF, level--. frame_ack with frame_valid=0
//   is ignored.
//  Commit and accepted ack on the same edge: level is unchanged, and both pointers advance.
//  Space is checked only at frame start. level can only fall during a fill, so a commit never overruns.
//  A committed frame becomes visible (frame_valid=1) on the edge after its last beat.
//  The write buffer is never the head buffer while level<NBUF, so the output never tears.
//  Buffer storage uses no reset; all control registers use it.
// CONFIGURATION
//  FF_PACK_EXT_ID_EN defined: the ID field latches the frameid input at frame start. The internal
//   counter is removed, and ID increments are no-ops.
//  Undefined: the ID comes from the internal ID_W-bit counter, which wraps to 0 after all-ones.
//   The frameid port exists and is ignored.
// TESTING
//  T1 IN_W=1,PAYLOAD=625,NBUF=2: 625 beats of alternating 1/0 with no ack -> frame_valid=1 one edge
//   after the last beat; frame_data[23:0]=0, [24]=1, [25]=0; level=1.
//  T2 Three back-to-back frames with no ack -> frames 0 and 1 buffered (level=2). The third frame
//   pulses overflow once at its first beat and gives drop_cnt=1. The next committed frame has ID=3.
//  T3 Fill with ack asserted on the commit edge -> level stays 1; the popped frame has ID 0 and the
//   new head has ID 1.
//  T4 start dropped after 300 beats, then a full frame -> busy clears, no commit; the next frame has
//   ID=0 and holds only post-abort data.
//  T5 IN_W=4,PAYLOAD=16,NBUF=4, beats 0x1,0x2,0x3,0x4 -> payload=16'h4321. After 4 frames, wr_ptr
//   wraps to 0 and level=4.
//  T6 FF_PACK_EXT_ID_EN with frameid=24'hABCDEF at the first beat, then changed mid-frame ->
//   frame_data[23:0]=24'hABCDEF. Reset asserted mid-fill -> level=0, frame_valid=0, busy=0.

Source files
------------

// File: rtl/ff_frame_packer_if.sv
// Stream-side and consumer-side signal bundle for ff_frame_packer.
// The master modport is the environment (demodulator plus MAC consumer).
// The slave modport is the packer itself.
interface ff_frame_packer_if #(
  parameter int IN_W         = 1,
  parameter int PAYLOAD_BITS = 625,
  parameter int ID_W         = 24,
  parameter int NBUF         = 2
);
  localparam int FRAME_W = ID_W + PAYLOAD_BITS;
  localparam int LVL_W   = $clog2(NBUF + 1);

  logic               ff_en;
  logic [IN_W-1:0]    ff_data;
  logic               start;
  logic               frame_valid;
  logic [FRAME_W-1:0] frame_data;
  logic               frame_ack;
  logic [LVL_W-1:0]   level;
  logic               busy;
  logic               overflow;
  logic [15:0]        drop_cnt;
  logic [ID_W-1:0]    frameid;

  modport master (
    output ff_en, ff_data, start, frame_ack, frameid,
    input  frame_valid, frame_data, level, busy, overflow, drop_cnt
  );

  modport slave (
    input  ff_en, ff_data, start, frame_ack, frameid,
    output frame_valid, frame_data, level, busy, overflow, drop_cnt
  );
endinterface

// File: rtl/ff_frame_packer.sv
// ff_frame_packer: packs IN_W-bit stream beats into {payload, ID} frames.
// Completed frames are held in an NBUF-deep ring and handed to the consumer
// through a valid/ack handshake. When every buffer is full, a whole incoming
// frame is discarded and counted instead.
// Optional build macro: FF_PACK_EXT_ID_EN. When it is defined, the ID field
// is taken from the frameid input at frame start. When it is undefined, a
// free-running internal ID counter supplies the ID.
module ff_frame_packer #(
  parameter int IN_W         = 1,
  parameter int PAYLOAD_BITS = 625,
  parameter int ID_W         = 24,
  parameter int NBUF         = 2
) (
  input  logic               ff_clk,
  input  logic               reset,
  ff_frame_packer_if.slave   bus
);
  localparam int FRAME_W = ID_W + PAYLOAD_BITS;
  localparam int BEATS   = PAYLOAD_BITS / IN_W;
  localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W   = $clog2(NBUF);
  localparam int LVL_W   = $clog2(NBUF + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DROP = 2'd2} state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]   level_r, level_nxt_s;
  logic               valid_r, overflow_r;
  logic [15:0]        drop_cnt_r;
  logic [FRAME_W-1:0] buf_r [NBUF];
  logic [ID_W-1:0]    id_src_s;

  logic beat_s, space_s, last_s, pop_s;
  logic wr_en_s, id_lat_s, commit_s, drop_begin_s, drop_done_s, busy_s;

  // Advance a ring pointer, wrapping modulo NBUF.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NBUF - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // beat_cnt is 0 whenever the FSM is in IDLE, so last_s also covers BEATS==1.
  assign beat_s  = bus.ff_en & bus.start;
  assign space_s = (level_r != LVL_W'(NBUF));
  assign last_s  = (beat_cnt_r == CNT_W'(BEATS - 1));
  assign pop_s   = bus.frame_ack & valid_r;

`ifdef FF_PACK_EXT_ID_EN
  assign id_src_s = bus.frameid;
`else
  logic [ID_W-1:0] id_cnt_r;
  assign id_src_s = id_cnt_r;

  // Internal frame-ID counter: it advances once per committed or dropped frame and wraps at all-ones.
  always_ff @(posedge ff_clk) begin
    if (reset) begin
      id_cnt_r <= {ID_W{1'b0}};
    end else if (commit_s | drop_done_s) begin
      id_cnt_r <= id_cnt_r + ID_W'(1);
    end
  end
`endif

  // State register.
  always_ff @(posedge ff_clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a low start level aborts any frame in progress.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (beat_s && !last_s) begin
          state_nxt_s = space_s ? FILL : DROP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FILL, DROP: begin
        if (!bus.start || (beat_s && last_s)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode: datapath strobes and the busy flag.
  always_comb begin
    wr_en_s      = 1'b0;
    id_lat_s     = 1'b0;
    drop_begin_s = 1'b0;
    drop_done_s  = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (beat_s) begin
          wr_en_s      = space_s;
          id_lat_s     = space_s;
          drop_begin_s = ~space_s;
          drop_done_s  = ~space_s & last_s;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      FILL: begin
        wr_en_s = beat_s;
        busy_s  = 1'b1;
      end
      DROP: begin
        drop_done_s = beat_s & last_s;
        busy_s      = 1'b1;
      end
      default: busy_s = 1'b0;
    endcase
  end

  assign commit_s = wr_en_s & last_s;

  // Occupancy update: a simultaneous commit and pop leave the level unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({commit_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Control registers: beat counter, ring pointers, occupancy, drop accounting.
  always_ff @(posedge ff_clk) begin
    if (reset) begin
      beat_cnt_r <= {CNT_W{1'b0}};
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= {LVL_W{1'b0}};
      valid_r    <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 16'h0000;
    end else begin
      if (state_nxt_s == IDLE) begin
        beat_cnt_r <= {CNT_W{1'b0}};
      end else if (beat_s) begin
        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
      end
      if (commit_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      level_r    <= level_nxt_s;
      valid_r    <= (level_nxt_s != {LVL_W{1'b0}});
      overflow_r <= drop_begin_s;
      if (drop_done_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  // Frame storage (not reset): write payload beats and latch the ID at frame start.
  always_ff @(posedge ff_clk) begin
    if (wr_en_s) begin
      buf_r[wr_ptr_r][ID_W + int'(beat_cnt_r) * IN_W +: IN_W] <= bus.ff_data;
    end
    if (id_lat_s) begin
      buf_r[wr_ptr_r][ID_W-1:0] <= id_src_s;
    end
  end

`ifndef FF_PACK_EXT_ID_EN
  logic unused_frameid_s;
  assign unused_frameid_s = ^bus.frameid;
`endif

  assign bus.frame_valid = valid_r;
  assign bus.frame_data  = buf_r[rd_ptr_r];
  assign bus.level       = level_r;
  assign bus.busy        = busy_s;
  assign bus.overflow    = overflow_r;
  assign bus.drop_cnt    = drop_cnt_r;
endmodule

// File: tb/tb_ff_frame_packer.sv
// Directed testbench for ff_frame_packer.
// It runs a default-parameter instance (1-bit beats, 625-bit payload, 2
// buffers) and a small instance (4-bit beats, 16-bit payload, 4 buffers).
module tb_ff_frame_packer;
  localparam int P0 = 625;
  localparam int ID = 24;

  logic ff_clk = 1'b0;
  logic reset  = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 ff_clk = ~ff_clk;

  ff_frame_packer_if #(.IN_W(1), .PAYLOAD_BITS(P0), .ID_W(ID), .NBUF(2)) if0 ();
  ff_frame_packer_if #(.IN_W(4), .PAYLOAD_BITS(16), .ID_W(ID), .NBUF(4)) if1 ();

  ff_frame_packer #(.IN_W(1), .PAYLOAD_BITS(P0), .ID_W(ID), .NBUF(2)) u0 (
    .ff_clk(ff_clk), .reset(reset), .bus(if0.slave));
  ff_frame_packer #(.IN_W(4), .PAYLOAD_BITS(16), .ID_W(ID), .NBUF(4)) u1 (
    .ff_clk(ff_clk), .reset(reset), .bus(if1.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Payload patterns: 0 = 1,0,1,0..., 1 = one every third bit, 2 = all ones.
  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return (k % 2) == 0;
      1:       return (k % 3) == 0;
      default: return 1'b1;
    endcase
  endfunction

  // In the external-ID build the expected ID is driven on frameid.
  // Otherwise frameid carries garbage that must be ignored.
  task automatic set_fid0(input logic [23:0] v);
`ifdef FF_PACK_EXT_ID_EN
    if0.frameid = v;
`else
    if0.frameid = ~v;
`endif
  endtask

  task automatic set_fid1(input logic [23:0] v);
`ifdef FF_PACK_EXT_ID_EN
    if1.frameid = v;
`else
    if1.frameid = v ^ 24'h5A5A5A;
`endif
  endtask

  // Send beats [from, to) of a pattern to instance 0; optionally ack on the final beat.
  task automatic send0(input int mode, input int from, input int to, input bit ack_last);
    for (int k = from; k < to; k++) begin
      if0.ff_en     = 1'b1;
      if0.ff_data   = pat(mode, k);
      if0.frame_ack = ack_last && (k == to - 1);
      @(posedge ff_clk); #1;
    end
    if0.ff_en     = 1'b0;
    if0.frame_ack = 1'b0;
  endtask

  task automatic pop0();
    if0.frame_ack = 1'b1;
    @(posedge ff_clk); #1;
    if0.frame_ack = 1'b0;
  endtask

  task automatic pop1();
    if1.frame_ack = 1'b1;
    @(posedge ff_clk); #1;
    if1.frame_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge ff_clk);
    #1 reset = 1'b0;
  endtask

  // Compare the head frame of instance 0 against an ID and a full payload pattern.
  task automatic check_frame0(input string tag, input logic [23:0] exp_id, input int mode);
    logic [639:0] e;
    logic [639:0] o;
    e = '0;
    for (int k = 0; k < P0; k++) e[k] = pat(mode, k);
    o = {15'b0, if0.frame_data[ID+P0-1:ID]};
    chk({tag, "_id"}, 64'(if0.frame_data[ID-1:0]), 64'(exp_id));
    for (int c = 0; c < 10; c++) chk({tag, "_pl"}, o[c*64 +: 64], e[c*64 +: 64]);
  endtask

  // Send one 4-beat frame to instance 1.
  task automatic send1(input logic [3:0] b0, input logic [3:0] b1,
                       input logic [3:0] b2, input logic [3:0] b3);
    logic [15:0] bb;
    bb = {b3, b2, b1, b0};
    for (int k = 0; k < 4; k++) begin
      if1.ff_en   = 1'b1;
      if1.ff_data = bb[k*4 +: 4];
      @(posedge ff_clk); #1;
    end
    if1.ff_en = 1'b0;
  endtask

  initial begin
    logic [15:0] exp1 [5];
    exp1[0] = 16'h4321; exp1[1] = 16'h8765; exp1[2] = 16'hCBA9;
    exp1[3] = 16'h0FED; exp1[4] = 16'hDCBA;

    if0.ff_en = 1'b0; if0.ff_data = '0; if0.start = 1'b0; if0.frame_ack = 1'b0; if0.frameid = '0;
    if1.ff_en = 1'b0; if1.ff_data = '0; if1.start = 1'b0; if1.frame_ack = 1'b0; if1.frameid = '0;
    repeat (3) @(posedge ff_clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_valid", 64'(if0.frame_valid), 64'd0);
    chk("rst_level", 64'(if0.level), 64'd0);
    chk("rst_busy", 64'(if0.busy), 64'd0);
    chk("rst_ovf", 64'(if0.overflow), 64'd0);
    chk("rst_drop", 64'(if0.drop_cnt), 64'd0);

    // T1: alternating frame, visible one edge after its last beat
    if0.start = 1'b1;
    set_fid0(24'd0);
    send0(0, 0, P0 - 1, 1'b0);
    chk("t1_busy_mid", 64'(if0.busy), 64'd1);
    chk("t1_valid_mid", 64'(if0.frame_valid), 64'd0);
    send0(0, P0 - 1, P0, 1'b0);
    chk("t1_valid", 64'(if0.frame_valid), 64'd1);
    chk("t1_level", 64'(if0.level), 64'd1);
    chk("t1_busy", 64'(if0.busy), 64'd0);
    chk("t1_bit24", 64'(if0.frame_data[24]), 64'd1);
    chk("t1_bit25", 64'(if0.frame_data[25]), 64'd0);
    check_frame0("t1", 24'd0, 0);

    // T2: second frame buffered, third dropped, next one carries ID 3
    set_fid0(24'd1);
    send0(1, 0, P0, 1'b0);
    chk("t2_level2", 64'(if0.level), 64'd2);
    set_fid0(24'd2);
    send0(1, 0, 1, 1'b0);
    chk("t2_ovf_pulse", 64'(if0.overflow), 64'd1);
    chk("t2_busy_drop", 64'(if0.busy), 64'd1);
    send0(1, 1, 2, 1'b0);
    chk("t2_ovf_clear", 64'(if0.overflow), 64'd0);
    send0(1, 2, P0, 1'b0);
    chk("t2_drop_cnt", 64'(if0.drop_cnt), 64'd1);
    chk("t2_level_kept", 64'(if0.level), 64'd2);
    chk("t2_busy_done", 64'(if0.busy), 64'd0);
    check_frame0("t2_head0", 24'd0, 0);
    pop0();
    chk("t2_level_pop1", 64'(if0.level), 64'd1);
    check_frame0("t2_head1", 24'd1, 1);
    pop0();
    chk("t2_level_pop2", 64'(if0.level), 64'd0);
    chk("t2_valid_empty", 64'(if0.frame_valid), 64'd0);
    pop0();
    chk("t2_ack_empty", 64'(if0.level), 64'd0);
    set_fid0(24'd3);
    send0(0, 0, P0, 1'b0);
    check_frame0("t2_id3", 24'd3, 0);

    // T3: commit and ack on the same edge
    do_reset();
    set_fid0(24'd0);
    send0(0, 0, P0, 1'b0);
    set_fid0(24'd1);
    send0(1, 0, P0 - 1, 1'b0);
    chk("t3_popped_id", 64'(if0.frame_data[ID-1:0]), 64'd0);
    send0(1, P0 - 1, P0, 1'b1);
    chk("t3_level", 64'(if0.level), 64'd1);
    check_frame0("t3_head", 24'd1, 1);

    // T4: abort after 300 beats, then a clean frame
    do_reset();
    set_fid0(24'd0);
    send0(2, 0, 300, 1'b0);
    chk("t4_busy_fill", 64'(if0.busy), 64'd1);
    if0.start = 1'b0;
    @(posedge ff_clk); #1;
    chk("t4_busy_abort", 64'(if0.busy), 64'd0);
    chk("t4_level_abort", 64'(if0.level), 64'd0);
    if0.start = 1'b1;
    send0(0, 0, P0, 1'b0);
    chk("t4_level", 64'(if0.level), 64'd1);
    check_frame0("t4", 24'd0, 0);

    // T6: ID latched at the first beat; then reset during a fill
    set_fid0(24'hABCDEF);
    send0(1, 0, 10, 1'b0);
    if0.frameid = 24'h123456;
    send0(1, 10, P0, 1'b0);
    chk("t6_level", 64'(if0.level), 64'd2);
    pop0();
`ifdef FF_PACK_EXT_ID_EN
    chk("t6_id", 64'(if0.frame_data[ID-1:0]), 64'hABCDEF);
`else
    chk("t6_id", 64'(if0.frame_data[ID-1:0]), 64'd1);
`endif
    send0(0, 0, 100, 1'b0);
    chk("t6_busy_pre", 64'(if0.busy), 64'd1);
    reset = 1'b1;
    @(posedge ff_clk); #1;
    reset = 1'b0;
    chk("t6_rst_level", 64'(if0.level), 64'd0);
    chk("t6_rst_valid", 64'(if0.frame_valid), 64'd0);
    chk("t6_rst_busy", 64'(if0.busy), 64'd0);

    // T5: 4-bit beats, 4 buffers, ring wrap
    if1.start = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_fid1(24'(f));
      send1(4'(4*f + 1), 4'(4*f + 2), 4'(4*f + 3), 4'(4*f + 4));
    end
    chk("t5_level4", 64'(if1.level), 64'd4);
    chk("t5_head_pl", 64'(if1.frame_data[ID+15:ID]), 64'(exp1[0]));
    chk("t5_head_id", 64'(if1.frame_data[ID-1:0]), 64'd0);
    pop1();
    chk("t5_level3", 64'(if1.level), 64'd3);
    set_fid1(24'd4);
    send1(4'hA, 4'hB, 4'hC, 4'hD);
    chk("t5_level_wrap", 64'(if1.level), 64'd4);
    for (int f = 1; f < 5; f++) begin
      chk("t5_pl", 64'(if1.frame_data[ID+15:ID]), 64'(exp1[f]));
      chk("t5_id", 64'(if1.frame_data[ID-1:0]), 64'(f));
      pop1();
    end
    chk("t5_empty", 64'(if1.frame_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
